// File: rtl/dma_chunk_copier_if.sv
// DMA channel bundle between the chunk copier (master) and the read/write DMA engines (slave).
interface dma_chunk_copier_if #(
  parameter int ADDR_WIDTH = 64,
  parameter int SIZE_WIDTH = 43,
  parameter int DATA_WIDTH = 512
);
  logic                  dma_rd_go;
  logic                  dma_wr_go;
  logic [ADDR_WIDTH-1:0] dma_rd_addr;
  logic [ADDR_WIDTH-1:0] dma_wr_addr;
  logic [SIZE_WIDTH-1:0] dma_rd_size;
  logic [SIZE_WIDTH-1:0] dma_wr_size;
  logic                  dma_rd_en;
  logic                  dma_empty;
  logic [DATA_WIDTH-1:0] dma_rd_data;
  logic                  dma_rd_done;
  logic                  dma_wr_en;
  logic                  dma_full;
  logic [DATA_WIDTH-1:0] dma_wr_data;
  logic                  dma_wr_done;

  modport master (
    output dma_rd_go, dma_wr_go, dma_rd_addr, dma_wr_addr, dma_rd_size, dma_wr_size,
    output dma_rd_en, dma_wr_en, dma_wr_data,
    input  dma_empty, dma_rd_data, dma_rd_done, dma_full, dma_wr_done
  );

  modport slave (
    input  dma_rd_go, dma_wr_go, dma_rd_addr, dma_wr_addr, dma_rd_size, dma_wr_size,
    input  dma_rd_en, dma_wr_en, dma_wr_data,
    output dma_empty, dma_rd_data, dma_rd_done, dma_full, dma_wr_done
  );
endinterface

// File: rtl/dma_chunk_copier.sv
// Chunked DMA copy sequencer with an internal decoupling FIFO.
// Optional job cycle counter on the `cycles` port when DMA_COPY_PERF_CNT_EN is defined.
module dma_chunk_copier #(
  parameter int ADDR_WIDTH = 64,
  parameter int SIZE_WIDTH = 43,
  parameter int DATA_WIDTH = 512,
  parameter int CL_BYTES   = 64,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  go,
  input  logic [ADDR_WIDTH-1:0] rd_base,
  input  logic [ADDR_WIDTH-1:0] wr_base,
  input  logic [SIZE_WIDTH-1:0] size,
  input  logic [SIZE_WIDTH-1:0] chunk_lines,
  output logic                  busy,
  output logic                  done,
`ifdef DMA_COPY_PERF_CNT_EN
  output logic [31:0]           cycles,
`endif
  dma_chunk_copier_if.master    dma
);
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FIFO_FULL = CNT_W'(FIFO_DEPTH);

  typedef enum logic [2:0] {IDLE, START, XFER, NEXT, DONE} state_t;
  state_t state, next_state;

  logic [ADDR_WIDTH-1:0] rd_addr_q, wr_addr_q, stride;
  logic [SIZE_WIDTH-1:0] remaining_q, chunk_q, len_q, rem_after, rd_cnt, wr_cnt;
  logic [DATA_WIDTH-1:0] fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      fifo_wr_ptr, fifo_rd_ptr;
  logic [CNT_W-1:0]      fifo_count;
  logic                  go_accept, push, pop, done_q;
  logic                  rd_done_unused;

  function automatic logic [SIZE_WIDTH-1:0] chunk_len(input logic [SIZE_WIDTH-1:0] rem,
                                                      input logic [SIZE_WIDTH-1:0] lim);
    return (lim == '0 || rem < lim) ? rem : lim;
  endfunction

  // Read-channel completion is informational; chunk completion follows the write side.
  assign rd_done_unused = dma.dma_rd_done;
  assign go_accept      = go && (state == IDLE);
  assign rem_after      = remaining_q - len_q;
  assign stride         = ADDR_WIDTH'(len_q) * ADDR_WIDTH'(CL_BYTES);
  assign push           = dma.dma_rd_en;
  assign pop            = dma.dma_wr_en;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (go) next_state = (size == '0) ? DONE : START;
      START:   next_state = XFER;
      XFER:    if (wr_cnt == len_q && dma.dma_wr_done) next_state = NEXT;
      NEXT:    next_state = (rem_after != '0) ? START : DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    busy            = (state == START) || (state == XFER) || (state == NEXT);
    done            = (state == DONE) || done_q;
    dma.dma_rd_go   = (state == START);
    dma.dma_wr_go   = (state == START);
    dma.dma_rd_addr = rd_addr_q;
    dma.dma_wr_addr = wr_addr_q;
    dma.dma_rd_size = len_q;
    dma.dma_wr_size = len_q;
    dma.dma_rd_en   = (state == XFER) && !dma.dma_empty && (fifo_count < FIFO_FULL) && (rd_cnt < len_q);
    dma.dma_wr_en   = (state == XFER) && !dma.dma_full && (fifo_count != '0) && (wr_cnt < len_q);
    dma.dma_wr_data = (fifo_count != '0) ? fifo_mem[fifo_rd_ptr] : '0;
  end

  // Job bookkeeping: the next chunk's length and addresses are prepared before START
  // so they stay stable for the whole chunk.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_addr_q   <= '0;
      wr_addr_q   <= '0;
      remaining_q <= '0;
      chunk_q     <= '0;
      len_q       <= '0;
      done_q      <= 1'b0;
    end else if (go_accept) begin
      rd_addr_q   <= rd_base;
      wr_addr_q   <= wr_base;
      remaining_q <= size;
      chunk_q     <= chunk_lines;
      len_q       <= chunk_len(size, chunk_lines);
      done_q      <= 1'b0;
    end else if (state == NEXT) begin
      rd_addr_q   <= rd_addr_q + stride;
      wr_addr_q   <= wr_addr_q + stride;
      remaining_q <= rem_after;
      len_q       <= chunk_len(rem_after, chunk_q);
    end else if (state == DONE) begin
      done_q      <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_cnt <= '0;
      wr_cnt <= '0;
    end else if (state == START) begin
      rd_cnt <= '0;
      wr_cnt <= '0;
    end else begin
      if (push) rd_cnt <= rd_cnt + SIZE_WIDTH'(1);
      if (pop)  wr_cnt <= wr_cnt + SIZE_WIDTH'(1);
    end
  end

  // Depth is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fifo_wr_ptr <= '0;
      fifo_rd_ptr <= '0;
      fifo_count  <= '0;
    end else begin
      if (push) fifo_wr_ptr <= fifo_wr_ptr + PTR_W'(1);
      if (pop)  fifo_rd_ptr <= fifo_rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CNT_W'(1);
        2'b01:   fifo_count <= fifo_count - CNT_W'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[fifo_wr_ptr] <= dma.dma_rd_data;
  end

`ifdef DMA_COPY_PERF_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                             cycles <= '0;
    else if (go_accept)                  cycles <= '0;
    else if (busy && cycles != 32'hFFFF_FFFF) cycles <= cycles + 32'd1;
  end
`endif
endmodule
